// File: rtl/cic_ctrl_pkg.sv
// Shared types and frame layout for the CIC sample arbiter.
// CIC_SAMPLE_TIMESTAMP_EN adds an 8-bit capture timestamp and a fourth frame byte.
package cic_ctrl_pkg;

   localparam int SAMPLE_W     = 20;
   localparam int HDR_SYNC_BIT = 7;
   localparam int HDR_CH_BIT   = 6;
   localparam int HDR_TS_BIT   = 5;
   localparam int HDR_MSN_W    = 4;

`ifdef CIC_SAMPLE_TIMESTAMP_EN
   localparam int   FRAME_BYTES = 4;
   localparam logic TS_PRESENT  = 1'b1;
`else
   localparam int   FRAME_BYTES = 3;
   localparam logic TS_PRESENT  = 1'b0;
`endif

   typedef enum logic [2:0] {
      SER_IDLE = 3'd0,
      SER_HDR  = 3'd1,
      SER_TS   = 3'd2,
      SER_MID  = 3'd3,
      SER_LSB  = 3'd4
   } ser_state_t;

   typedef struct packed {
      logic                ch;
      logic [SAMPLE_W-1:0] data;
`ifdef CIC_SAMPLE_TIMESTAMP_EN
      logic [7:0]          ts;
`endif
   } sample_entry_t;

   function automatic logic [7:0] hdr_byte(input sample_entry_t e);
      logic [7:0] b;
      b                  = '0;
      b[HDR_SYNC_BIT]    = 1'b1;
      b[HDR_CH_BIT]      = e.ch;
      b[HDR_TS_BIT]      = TS_PRESENT;
      b[HDR_MSN_W-1:0]   = e.data[SAMPLE_W-1 -: HDR_MSN_W];
      return b;
   endfunction

endpackage

// File: rtl/cic_sample_fifo.sv
// Small synchronous FIFO with registered occupancy; push while full is accepted
// only when a pop happens in the same cycle.
module cic_sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LVL_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full_o     = (count == LVL_W'(DEPTH));
   assign empty_o    = (count == '0);
   assign do_pop     = pop_i & ~empty_o;
   assign do_push    = push_i & (~full_o | do_pop);
   assign pop_data_o = mem[rd_ptr];
   assign level_o    = count;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cic_sample_arbiter.sv
// Captures CIC1/CIC2 decimated samples, arbitrates them round-robin into a FIFO and
// streams each as a byte frame. CIC_SAMPLE_TIMESTAMP_EN adds a timestamp byte.
//
// state    | meaning
// SER_IDLE | no frame in flight, waiting for a FIFO entry
// SER_HDR  | header byte {sync, ch, ts_flag, 0, data[19:16]} on byte_o
// SER_TS   | capture timestamp byte (timestamp build only)
// SER_MID  | data[15:8] on byte_o
// SER_LSB  | data[7:0] on byte_o; next frame may start without an idle cycle
module cic_sample_arbiter
   import cic_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [DATA_WIDTH-1:0] ch0_data_i,
   input  logic                  ch0_strobe_i,
   input  logic [DATA_WIDTH-1:0] ch1_data_i,
   input  logic                  ch1_strobe_i,
   input  logic [1:0]            ch_enable_i,
   output logic [7:0]            byte_o,
   output logic                  byte_valid_o,
   input  logic                  byte_ready_i,
   output logic                  frame_start_o,
   output logic                  overflow_o,
   input  logic                  overflow_clr_i,
   output logic [LVL_WIDTH-1:0]  fifo_level_o
);

   logic [1:0]          strobe_q;
   logic                hist_vld;
   logic [1:0]          edge_det;
   logic [1:0]          pending;
   logic [1:0]          grant;
   logic                last_grant;
   logic [SAMPLE_W-1:0] in_data  [2];
   logic [SAMPLE_W-1:0] cap_data [2];
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic                hs;
   sample_entry_t       wr_entry;
   sample_entry_t       rd_entry;
   sample_entry_t       frame_q;
   ser_state_t          state;

   assign in_data[0] = SAMPLE_W'(ch0_data_i);
   assign in_data[1] = SAMPLE_W'(ch1_data_i);

   // hist_vld keeps the first post-reset sample of a high strobe from looking like an edge
   assign edge_det = {ch1_strobe_i, ch0_strobe_i} & ~strobe_q & ch_enable_i & {2{hist_vld}};

   always_comb begin
      grant = 2'b00;
      if (!fifo_full) begin
         case (pending)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

`ifdef CIC_SAMPLE_TIMESTAMP_EN
   logic [7:0] ts_cnt;
   logic [7:0] cap_ts [2];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ts_cnt    <= '0;
         cap_ts[0] <= '0;
         cap_ts[1] <= '0;
      end else begin
         ts_cnt <= ts_cnt + 8'd1;
         for (int k = 0; k < 2; k++) begin
            if (edge_det[k]) cap_ts[k] <= ts_cnt;
         end
      end
   end

   assign wr_entry = '{ch: grant[1], data: cap_data[grant[1]], ts: cap_ts[grant[1]]};
`else
   assign wr_entry = '{ch: grant[1], data: cap_data[grant[1]]};
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         strobe_q    <= '0;
         hist_vld    <= 1'b0;
         pending     <= '0;
         cap_data[0] <= '0;
         cap_data[1] <= '0;
         last_grant  <= 1'b1;
         overflow_o  <= 1'b0;
      end else begin
         strobe_q <= {ch1_strobe_i, ch0_strobe_i};
         hist_vld <= 1'b1;
         for (int k = 0; k < 2; k++) begin
            if (edge_det[k]) begin
               cap_data[k] <= in_data[k];
               pending[k]  <= 1'b1;
            end else if (grant[k]) begin
               pending[k] <= 1'b0;
            end
         end
         if (|grant) last_grant <= grant[1];
         // an edge landing on a granted channel is a refill, not a loss
         if (|(edge_det & pending & ~grant)) overflow_o <= 1'b1;
         else if (overflow_clr_i)            overflow_o <= 1'b0;
      end
   end

   cic_sample_fifo #(
      .WIDTH ($bits(sample_entry_t)),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_WIDTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .push_i      (|grant),
      .push_data_i (wr_entry),
      .pop_i       (fifo_pop),
      .pop_data_o  (rd_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level_o)
   );

   assign hs       = (state != SER_IDLE) & byte_ready_i;
   assign fifo_pop = ~fifo_empty & ((state == SER_IDLE) | ((state == SER_LSB) & hs));

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state   <= SER_IDLE;
         frame_q <= '0;
      end else begin
         if (fifo_pop) frame_q <= rd_entry;
         case (state)
            SER_IDLE: if (!fifo_empty) state <= SER_HDR;
`ifdef CIC_SAMPLE_TIMESTAMP_EN
            SER_HDR:  if (hs) state <= SER_TS;
            SER_TS:   if (hs) state <= SER_MID;
`else
            SER_HDR:  if (hs) state <= SER_MID;
`endif
            SER_MID:  if (hs) state <= SER_LSB;
            SER_LSB:  if (hs) state <= fifo_empty ? SER_IDLE : SER_HDR;
            default:  state <= SER_IDLE;
         endcase
      end
   end

   always_comb begin
      byte_o = 8'h00;
      case (state)
         SER_HDR: byte_o = hdr_byte(frame_q);
`ifdef CIC_SAMPLE_TIMESTAMP_EN
         SER_TS:  byte_o = frame_q.ts;
`endif
         SER_MID: byte_o = frame_q.data[15:8];
         SER_LSB: byte_o = frame_q.data[7:0];
         default: byte_o = 8'h00;
      endcase
   end

   assign byte_valid_o  = (state != SER_IDLE);
   assign frame_start_o = (state == SER_HDR);

endmodule

// File: tb/tb_cic_sample_arbiter.sv
// Self-checking bench for cic_sample_arbiter: vector table, corner-case sequences and
// a randomized run scored against per-channel expected-sample queues.
`timescale 1ns/1ps
module tb_cic_sample_arbiter;

`ifdef CIC_SAMPLE_TIMESTAMP_EN
   localparam bit TS_EN = 1'b1;
   localparam int FB    = 4;
`else
   localparam bit TS_EN = 1'b0;
   localparam int FB    = 3;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [19:0] ch0_data = '0;
   logic [19:0] ch1_data = '0;
   logic        ch0_strobe = 1'b0;
   logic        ch1_strobe = 1'b0;
   logic [1:0]  ch_en = 2'b11;
   logic [7:0]  bout;
   logic        bvalid;
   logic        ready = 1'b1;
   logic        fstart;
   logic        ovf;
   logic        ovf_clr = 1'b0;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   cic_sample_arbiter dut (
      .clk_i          (clk),
      .rstn_i         (rstn),
      .ch0_data_i     (ch0_data),
      .ch0_strobe_i   (ch0_strobe),
      .ch1_data_i     (ch1_data),
      .ch1_strobe_i   (ch1_strobe),
      .ch_enable_i    (ch_en),
      .byte_o         (bout),
      .byte_valid_o   (bvalid),
      .byte_ready_i   (ready),
      .frame_start_o  (fstart),
      .overflow_o     (ovf),
      .overflow_clr_i (ovf_clr),
      .fifo_level_o   (level)
   );

   // cycles since reset release == the timestamp counter value
   always @(posedge clk or negedge rstn)
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_byte(input logic ch, input logic [19:0] d,
                                           input logic [7:0] ts, input int idx);
      int i;
      i = idx;
      if (i == 0) return {1'b1, ch, TS_EN, 1'b0, d[19:16]};
      if (TS_EN) begin
         if (i == 1) return ts;
         i = i - 1;
      end
      if (i == 1) return d[15:8];
      return d[7:0];
   endfunction

   task automatic do_reset();
      rstn = 1'b0; ch0_strobe = 1'b0; ch1_strobe = 1'b0;
      ch_en = 2'b11; ready = 1'b1; ovf_clr = 1'b0;
      tick(); tick();
      rstn = 1'b1;
      tick(); tick();
   endtask

   task automatic check_stream(input string nm, input logic [7:0] exp [8], input int n);
      for (int i = 0; i < n; i++) begin
         chk({nm, " valid"}, bvalid, 1);
         chk({nm, " byte"}, bout, exp[i]);
         chk({nm, " fs"}, fstart, 32'((i % FB) == 0));
         tick();
      end
      chk({nm, " idle"}, bvalid, 0);
   endtask

   task automatic run_single(input string nm, input logic ch, input logic [19:0] d);
      logic [7:0] ex [8];
      logic [7:0] tsv;
      tsv = cyc[7:0];
      if (ch) begin ch1_data = d; ch1_strobe = 1'b1; end
      else    begin ch0_data = d; ch0_strobe = 1'b1; end
      tick(); tick();
      chk({nm, " early"}, bvalid, 0);
      tick();
      ch0_strobe = 1'b0; ch1_strobe = 1'b0;
      for (int i = 0; i < FB; i++) ex[i] = exp_byte(ch, d, tsv, i);
      check_stream(nm, ex, FB);
      tick();
   endtask

   task automatic run_tie(input string nm, input logic [19:0] d0, input logic [19:0] d1,
                          input logic first);
      logic [7:0] ex [8];
      logic [7:0] tsv;
      tsv = cyc[7:0];
      ch0_data = d0; ch1_data = d1; ch0_strobe = 1'b1; ch1_strobe = 1'b1;
      tick(); tick(); tick();
      ch0_strobe = 1'b0; ch1_strobe = 1'b0;
      for (int i = 0; i < FB; i++) begin
         ex[i]      = exp_byte(first, first ? d1 : d0, tsv, i);
         ex[FB + i] = exp_byte(~first, first ? d0 : d1, tsv, i);
      end
      check_stream(nm, ex, 2 * FB);
      tick();
   endtask

   // ---------------- monitor / scoreboard for the random phase ----------------
   logic [27:0] q0[$];
   logic [27:0] q1[$];
   logic        mon_en = 1'b0;
   int          midx = 0;
   logic [7:0]  mbuf [4];
   logic        pv = 1'b0, pr = 1'b0;
   logic [7:0]  pb = '0;

   always @(negedge clk) begin
      logic [27:0] got, want;
      logic        mch;
      if (mon_en) begin
         if (pv && !pr) begin
            chk("hold valid", bvalid, 1);
            chk("hold byte", bout, pb);
         end
         if (bvalid && ready) begin
            chk("mon fs", fstart, 32'(midx == 0));
            mbuf[midx] = bout;
            midx++;
            if (midx == FB) begin
               midx = 0;
               mch  = mbuf[0][6];
               chk("mon hdr bits", {mbuf[0][7], mbuf[0][5:4]}, {1'b1, TS_EN, 1'b0});
               got = {(TS_EN ? mbuf[1] : 8'h00), mbuf[0][3:0], mbuf[FB-2], mbuf[FB-1]};
               if (mch) begin
                  chk("mon q1 nonempty", 32'(q1.size() != 0), 1);
                  if (q1.size() != 0) begin want = q1.pop_front(); chk("mon ch1 sample", got, want); end
               end else begin
                  chk("mon q0 nonempty", 32'(q0.size() != 0), 1);
                  if (q0.size() != 0) begin want = q0.pop_front(); chk("mon ch0 sample", got, want); end
               end
            end
         end
         pv = bvalid; pr = ready; pb = bout;
      end else begin
         midx = 0; pv = 1'b0;
      end
   end

   typedef struct {
      logic        ch;
      logic [19:0] data;
      logic [7:0]  b0, b1, b2;
   } vec_t;

   initial begin
      vec_t       vecs [5];
      logic [7:0] ex [8];
      logic [7:0] tsv;
      logic [7:0] lsbs [8];
      logic [7:0] exp_lsb [6];
      int         nl, idx, hi_cnt [2], gap_cnt [2];
      logic [19:0] rd;

      vecs[0] = '{1'b0, 20'h003A5, 8'h80, 8'h03, 8'hA5};
      vecs[1] = '{1'b1, 20'hABCDE, 8'hCA, 8'hBC, 8'hDE};
      vecs[2] = '{1'b0, 20'hFFFFF, 8'h8F, 8'hFF, 8'hFF};
      vecs[3] = '{1'b1, 20'h00000, 8'hC0, 8'h00, 8'h00};
      vecs[4] = '{1'b0, 20'h12345, 8'h81, 8'h23, 8'h45};

      do_reset();
      chk("rst valid", bvalid, 0);
      chk("rst byte", bout, 0);
      chk("rst fs", fstart, 0);
      chk("rst ovf", ovf, 0);
      chk("rst level", level, 0);

      // vector table: single sample, exact 3-cycle latency, 3 bytes back to back
      for (int v = 0; v < 5; v++) begin
         tsv = cyc[7:0];
         if (vecs[v].ch) begin ch1_data = vecs[v].data; ch1_strobe = 1'b1; end
         else            begin ch0_data = vecs[v].data; ch0_strobe = 1'b1; end
         tick(); tick();
         chk("vec early", bvalid, 0);
         tick();
         ch0_strobe = 1'b0; ch1_strobe = 1'b0;
         ex[0] = vecs[v].b0 | (TS_EN ? 8'h20 : 8'h00);
         idx = 1;
         if (TS_EN) begin ex[1] = tsv; idx = 2; end
         ex[idx] = vecs[v].b1;
         ex[idx + 1] = vecs[v].b2;
         check_stream("vec", ex, FB);
         tick(); tick();
      end

      // round-robin ties
      do_reset();
      run_tie("tieA", 20'h12345, 20'hABCDE, 1'b0);
      run_tie("tieB", 20'h0F0F0, 20'h00C3C, 1'b0);
      run_single("pre_tieC", 1'b0, 20'h00011);
      run_tie("tieC", 20'h77777, 20'h88888, 1'b1);

      // backpressure mid-frame
      do_reset();
      ch1_data = 20'h5A6B7; ch1_strobe = 1'b1;
      tick(); tick(); tick();
      ch1_strobe = 1'b0;
      chk("stall hdr", bout, 8'hC5 | (TS_EN ? 8'h20 : 8'h00));
      for (int i = 0; i < FB - 2; i++) tick();
      chk("stall at mid", bout, 8'hA6);
      ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall valid", bvalid, 1);
         chk("stall byte", bout, 8'hA6);
      end
      ready = 1'b1;
      tick();
      chk("stall lsb", bout, 8'hB7);
      tick();
      chk("stall end", bvalid, 0);

      // FIFO fill, pending hold, overflow set/clear and priority
      do_reset();
      ready = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         ch1_data = 20'h00100 + 20'(k); ch1_strobe = 1'b1;
         tick(); tick();
         ch1_strobe = 1'b0;
         tick(); tick();
         if (k == 5) begin chk("fill level", level, 4); chk("fill ovf", ovf, 0); end
         if (k == 6) begin chk("pend level", level, 4); chk("pend ovf", ovf, 0); end
         if (k == 7) begin chk("ovf level", level, 4); chk("ovf set", ovf, 1); end
      end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("ovf clr", ovf, 0);
      ch1_data = 20'h00108; ch1_strobe = 1'b1; ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("ovf prio", ovf, 1);
      tick(); ch1_strobe = 1'b0;
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("ovf clr2", ovf, 0);
      ch_en = 2'b00;
      exp_lsb[0] = 8'h01; exp_lsb[1] = 8'h02; exp_lsb[2] = 8'h03;
      exp_lsb[3] = 8'h04; exp_lsb[4] = 8'h05; exp_lsb[5] = 8'h08;
      ready = 1'b1; nl = 0; idx = 0;
      for (int c = 0; c < 60; c++) begin
         if (bvalid) begin
            if (fstart) idx = 0;
            if (idx == FB - 1 && nl < 8) begin lsbs[nl] = bout; nl++; end
            idx++;
         end
         tick();
      end
      chk("drain count", nl, 6);
      for (int i = 0; i < 6 && i < nl; i++) chk("drain lsb", lsbs[i], exp_lsb[i]);
      chk("drain level", level, 0);
      ch_en = 2'b11;

      // async reset mid-frame; strobe high across reset must not produce a frame
      do_reset();
      ready = 1'b0;
      ch1_data = 20'h13579; ch1_strobe = 1'b1;
      tick(); tick();
      ch1_strobe = 1'b0;
      ch0_data = 20'h2468A; ch0_strobe = 1'b1;
      tick(); tick(); tick();
      chk("mr level", level, 1);
      ready = 1'b1;
      for (int i = 0; i < FB - 2; i++) tick();
      ready = 1'b0;
      chk("mr mid", bout, 8'h35);
      #2 rstn = 1'b0;
      #1;
      chk("mr valid", bvalid, 0);
      chk("mr level0", level, 0);
      chk("mr byte", bout, 0);
      tick(); tick();
      rstn = 1'b1; ready = 1'b1;
      nl = 0;
      for (int i = 0; i < 10; i++) begin
         if (bvalid) nl++;
         tick();
      end
      chk("mr no frame", nl, 0);
      chk("mr level after", level, 0);
      ch0_strobe = 1'b0; tick();
      ch0_strobe = 1'b1;
      tick(); tick();
      chk("mr re early", bvalid, 0);
      tick();
      chk("mr re hdr", bout, 8'h82 | (TS_EN ? 8'h20 : 8'h00));
      ch0_strobe = 1'b0;
      for (int i = 0; i < FB + 2; i++) tick();

`ifdef CIC_SAMPLE_TIMESTAMP_EN
      rstn = 1'b0; ch0_strobe = 1'b0; ch1_strobe = 1'b0; ready = 1'b1;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      ch0_data = 20'h003A5; ch0_strobe = 1'b1;
      tick(); tick(); tick();
      ch0_strobe = 1'b0;
      ex[0] = 8'hA0; ex[1] = 8'h07; ex[2] = 8'h03; ex[3] = 8'hA5;
      check_stream("ts", ex, 4);
`endif

      // randomized traffic against the per-channel scoreboard
      do_reset();
      mon_en = 1'b1;
      hi_cnt[0] = 0; hi_cnt[1] = 0;
      gap_cnt[0] = 3; gap_cnt[1] = 7;
      for (int c = 0; c < 1500; c++) begin
         ready = ($urandom_range(3) != 0);
         for (int k = 0; k < 2; k++) begin
            if (hi_cnt[k] > 0) begin
               hi_cnt[k]--;
               if (hi_cnt[k] == 0) begin
                  if (k == 0) ch0_strobe = 1'b0; else ch1_strobe = 1'b0;
               end
            end else if (gap_cnt[k] > 0) begin
               gap_cnt[k]--;
            end else begin
               rd = 20'($urandom);
               if (k == 0) rd = rd & 20'h003FF;
               ch_en[k] = ($urandom_range(7) != 0);
               if (k == 0) begin ch0_data = rd; ch0_strobe = 1'b1; end
               else        begin ch1_data = rd; ch1_strobe = 1'b1; end
               if (ch_en[k]) begin
                  if (k == 0) q0.push_back({(TS_EN ? cyc[7:0] : 8'h00), rd});
                  else        q1.push_back({(TS_EN ? cyc[7:0] : 8'h00), rd});
               end
               hi_cnt[k]  = 2;
               gap_cnt[k] = $urandom_range(30, 16);
            end
         end
         tick();
      end
      ch0_strobe = 1'b0; ch1_strobe = 1'b0; ready = 1'b1;
      for (int c = 0; c < 60; c++) tick();
      mon_en = 1'b0;
      chk("rand q0 drained", q0.size(), 0);
      chk("rand q1 drained", q1.size(), 0);
      chk("rand ovf", ovf, 0);
      chk("rand level", level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
